contador_ocupacion: RTL and testbench



---
 rtl/parking_pkg.sv | 13 +
 rtl/contador_ocupacion_if.sv | 33 +++
 rtl/bcd_updown.sv | 35 +++
 rtl/contador_ocupacion.sv | 106 ++++++++++
 tb/tb_contador_ocupacion.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/parking_pkg.sv
// Shared types for the parking occupancy tracker.
// State encoding and default lot capacity.
package parking_pkg;

  typedef enum logic [1:0] {
    VACIO   = 2'b00,
    PARCIAL = 2'b01,
    LLENO   = 2'b10
  } state_t;

  localparam int CAPACITY_DEF = 15;

endpackage

// File: rtl/contador_ocupacion_if.sv
// Detector-side pulses and lot status bundle.
// count_bcd exists only when OCUPACION_BCD_EN is defined.
interface contador_ocupacion_if #(
  parameter int WIDTH = 4
);
  logic             entrada;
  logic             salida;
  logic             err_clr;
  logic [WIDTH-1:0] count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;
`ifdef OCUPACION_BCD_EN
  logic [7:0]       count_bcd;
`endif

  modport master (
    output entrada, salida, err_clr,
`ifdef OCUPACION_BCD_EN
    input  count_bcd,
`endif
    input  count, empty, full, overflow, underflow
  );

  modport slave (
    input  entrada, salida, err_clr,
`ifdef OCUPACION_BCD_EN
    output count_bcd,
`endif
    output count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/bcd_updown.sv
// Two-digit BCD up/down counter; callers gate inc/dec
// so the value never leaves 0..99.
module bcd_updown (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  output logic [7:0] bcd
);
  logic [3:0] tens;
  logic [3:0] units;

  always_ff @(posedge clk) begin
    if (rst) begin
      tens  <= 4'd0;
      units <= 4'd0;
    end else if (inc & ~dec) begin
      if (units == 4'd9) begin
        units <= 4'd0;
        tens  <= tens + 4'd1;
      end else begin
        units <= units + 4'd1;
      end
    end else if (dec & ~inc) begin
      if (units == 4'd0) begin
        units <= 4'd9;
        tens  <= tens - 4'd1;
      end else begin
        units <= units - 4'd1;
      end
    end
  end

  assign bcd = {tens, units};
endmodule

// File: rtl/contador_ocupacion.sv
// Saturating parking occupancy counter with VACIO/PARCIAL/LLENO FSM.
// Optional BCD mirror of the count under OCUPACION_BCD_EN.
module contador_ocupacion
  import parking_pkg::*;
#(
  parameter int CAPACITY = CAPACITY_DEF,
  parameter int WIDTH    = 4
) (
  input logic clk,
  input logic rst,
  contador_ocupacion_if.slave bus
);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
  localparam logic [WIDTH-1:0] CAP_M1 = WIDTH'(CAPACITY - 1);

  state_t           state;
  logic [WIDTH-1:0] count_q;
  logic             entrada_q;
  logic             salida_q;
  logic             ovf_q;
  logic             unf_q;
  logic             ent_ev;
  logic             sal_ev;
  logic             inc;
  logic             dec;

  assign ent_ev = bus.entrada & ~entrada_q;
  assign sal_ev = bus.salida & ~salida_q;
  // Simultaneous entry and exit cancel out
  assign inc    = ent_ev & ~sal_ev;
  assign dec    = sal_ev & ~ent_ev;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= VACIO;
      count_q   <= '0;
      entrada_q <= 1'b0;
      salida_q  <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      entrada_q <= bus.entrada;
      salida_q  <= bus.salida;
      ovf_q     <= ovf_q & ~bus.err_clr;
      unf_q     <= unf_q & ~bus.err_clr;
      case (state)
        VACIO: begin
          if (inc) begin
            count_q <= ONE;
            state   <= (CAPACITY == 1) ? LLENO : PARCIAL;
          end else if (dec) begin
            unf_q <= 1'b1;
          end
        end
        PARCIAL: begin
          if (inc) begin
            count_q <= count_q + ONE;
            state   <= (count_q == CAP_M1) ? LLENO : PARCIAL;
          end else if (dec) begin
            count_q <= count_q - ONE;
            state   <= (count_q == ONE) ? VACIO : PARCIAL;
          end
        end
        LLENO: begin
          if (inc) begin
            ovf_q <= 1'b1;
          end else if (dec) begin
            count_q <= count_q - ONE;
            state   <= (CAPACITY == 1) ? VACIO : PARCIAL;
          end
        end
        default: begin
          state   <= VACIO;
          count_q <= '0;
        end
      endcase
    end
  end

  assign bus.count     = count_q;
  assign bus.empty     = (state == VACIO);
  assign bus.full      = (state == LLENO);
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;

`ifdef OCUPACION_BCD_EN
  logic illegal;
  logic bcd_rst;
  logic bcd_inc;
  logic bcd_dec;

  // Mirror only the moves the binary counter actually takes
  assign illegal = !(state inside {VACIO, PARCIAL, LLENO});
  assign bcd_rst = rst | illegal;
  assign bcd_inc = inc & (state inside {VACIO, PARCIAL});
  assign bcd_dec = dec & (state inside {PARCIAL, LLENO});

  bcd_updown u_bcd (
    .clk (clk),
    .rst (bcd_rst),
    .inc (bcd_inc),
    .dec (bcd_dec),
    .bcd (bus.count_bcd)
  );
`endif
endmodule

// File: tb/tb_contador_ocupacion.sv
// Bench for contador_ocupacion: CAPACITY=4 and CAPACITY=15 instances
// driven in lockstep, checked against a table and an arithmetic model.
module tb_contador_ocupacion;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  contador_ocupacion_if #(.WIDTH(3)) b4 ();
  contador_ocupacion_if #(.WIDTH(4)) b15 ();

  contador_ocupacion #(.CAPACITY(4), .WIDTH(3)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (b4)
  );

  contador_ocupacion #(.CAPACITY(15), .WIDTH(4)) dut15 (
    .clk (clk),
    .rst (rst),
    .bus (b15)
  );

  int n_chk  = 0;
  int n_fail = 0;

  int cap  [2] = '{4, 15};
  int mcnt [2];
  bit mov  [2];
  bit mun  [2];
  bit pe;
  bit ps;

  typedef struct {
    bit r, e, s, c;
    int cnt;
    bit emp, ful, ov, un;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model(bit r, bit e, bit s, bit c);
    bit ee, se, oe, ue;
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        mcnt[i] = 0;
        mov[i]  = 0;
        mun[i]  = 0;
      end else begin
        ee = e && !pe;
        se = s && !ps;
        oe = 0;
        ue = 0;
        if (ee && !se) begin
          if (mcnt[i] == cap[i]) oe = 1;
          else mcnt[i]++;
        end else if (se && !ee) begin
          if (mcnt[i] == 0) ue = 1;
          else mcnt[i]--;
        end
        mov[i] = oe || (mov[i] && !c);
        mun[i] = ue || (mun[i] && !c);
      end
    end
    pe = r ? 1'b0 : e;
    ps = r ? 1'b0 : s;
  endtask

  task automatic chk_dut(string t, int i, int cnt, bit emp, bit ful,
                         bit ov, bit un);
    chk({t, ".count"}, cnt, mcnt[i]);
    chk({t, ".empty"}, int'(emp), int'(mcnt[i] == 0));
    chk({t, ".full"}, int'(ful), int'(mcnt[i] == cap[i]));
    chk({t, ".overflow"}, int'(ov), int'(mov[i]));
    chk({t, ".underflow"}, int'(un), int'(mun[i]));
  endtask

  function automatic int to_bcd(int v);
    return ((v / 10) << 4) | (v % 10);
  endfunction

  task automatic step(bit r, bit e, bit s, bit c);
    rst         = r;
    b4.entrada  = e;
    b15.entrada = e;
    b4.salida   = s;
    b15.salida  = s;
    b4.err_clr  = c;
    b15.err_clr = c;
    @(posedge clk);
    model(r, e, s, c);
    #1;
    chk_dut("d4", 0, int'(b4.count), b4.empty, b4.full,
            b4.overflow, b4.underflow);
    chk_dut("d15", 1, int'(b15.count), b15.empty, b15.full,
            b15.overflow, b15.underflow);
`ifdef OCUPACION_BCD_EN
    chk("d4.bcd", int'(b4.count_bcd), to_bcd(mcnt[0]));
    chk("d15.bcd", int'(b15.count_bcd), to_bcd(mcnt[1]));
`endif
  endtask

  initial begin
    // r e s c | cnt emp ful ov un  (CAPACITY=4 instance)
    tbl[0]  = '{1, 0, 0, 0, 0, 1, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 0, 1, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    tbl[3]  = '{0, 1, 0, 0, 2, 0, 0, 0, 0};
    tbl[4]  = '{0, 0, 0, 0, 2, 0, 0, 0, 0};
    tbl[5]  = '{0, 1, 0, 0, 3, 0, 0, 0, 0};
    tbl[6]  = '{0, 0, 0, 0, 3, 0, 0, 0, 0};
    tbl[7]  = '{0, 1, 0, 0, 4, 0, 1, 0, 0};
    tbl[8]  = '{0, 0, 0, 0, 4, 0, 1, 0, 0};
    tbl[9]  = '{0, 1, 0, 0, 4, 0, 1, 1, 0};
    tbl[10] = '{0, 0, 0, 0, 4, 0, 1, 1, 0};
    tbl[11] = '{0, 0, 1, 0, 3, 0, 0, 1, 0};
    tbl[12] = '{0, 0, 0, 1, 3, 0, 0, 0, 0};
    tbl[13] = '{0, 1, 1, 0, 3, 0, 0, 0, 0};
    tbl[14] = '{0, 1, 0, 0, 3, 0, 0, 0, 0};
    tbl[15] = '{0, 0, 0, 0, 3, 0, 0, 0, 0};
    tbl[16] = '{1, 0, 0, 0, 0, 1, 0, 0, 0};
    tbl[17] = '{0, 0, 1, 0, 0, 1, 0, 0, 1};
    tbl[18] = '{0, 0, 1, 1, 0, 1, 0, 0, 0};
    tbl[19] = '{0, 0, 0, 0, 0, 1, 0, 0, 0};

    b4.entrada  = 0;
    b4.salida   = 0;
    b4.err_clr  = 0;
    b15.entrada = 0;
    b15.salida  = 0;
    b15.err_clr = 0;
    pe = 0;
    ps = 0;

    for (int i = 0; i < 20; i++) begin
      step(tbl[i].r, tbl[i].e, tbl[i].s, tbl[i].c);
      chk($sformatf("tbl%0d.count", i), int'(b4.count), tbl[i].cnt);
      chk($sformatf("tbl%0d.empty", i), int'(b4.empty), int'(tbl[i].emp));
      chk($sformatf("tbl%0d.full", i), int'(b4.full), int'(tbl[i].ful));
      chk($sformatf("tbl%0d.ovf", i), int'(b4.overflow), int'(tbl[i].ov));
      chk($sformatf("tbl%0d.unf", i), int'(b4.underflow), int'(tbl[i].un));
    end

    // Held entrada for five cycles counts once
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    chk("held.count", int'(b15.count), 1);

    // Pulse high in the first cycle after reset counts
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("post_rst.count", int'(b15.count), 1);

    // Ten entries, one exit, then reset mid-sequence
    step(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 0, 0);
      step(0, 0, 0, 0);
    end
    chk("ten.count", int'(b15.count), 10);
`ifdef OCUPACION_BCD_EN
    chk("ten.bcd", int'(b15.count_bcd), 'h10);
`endif
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    chk("nine.count", int'(b15.count), 9);
`ifdef OCUPACION_BCD_EN
    chk("nine.bcd", int'(b15.count_bcd), 'h09);
`endif
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    chk("midrst.count", int'(b15.count), 0);
`ifdef OCUPACION_BCD_EN
    chk("midrst.bcd", int'(b15.count_bcd), 'h00);
`endif

    // Random traffic: entry-biased, then exit-biased
    for (int i = 0; i < 800; i++) begin
      bit r, e, s, c;
      int pen;
      pen = (i < 400) ? 60 : 25;
      r = ($urandom_range(0, 149) == 0);
      e = ($urandom_range(0, 99) < pen);
      s = ($urandom_range(0, 99) < (85 - pen));
      c = ($urandom_range(0, 9) == 0);
      step(r, e, s, c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
